uart_frame_tx: RTL
==================

Name: uart_frame_tx

Overview:
- Serial-side consumer of the wide-frame send/data/send_done handshake used by the UART frame producers.
- Accepts one FRAME_BITS-wide frame, serializes it as FRAME_BITS/8 bytes in 8N1 UART format on tx, then reports completion on send_done.
- Sits between the frame producer (test pattern or application logic) and the board UART TX pin.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 2.
- FRAME_BITS, 320, frame width in bits; must be a multiple of 8. NBYTES = FRAME_BITS/8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  frame request; level, held high by the producer until it sees send_done.
- data  input  FRAME_BITS  frame payload; sampled only on acceptance.
- send_done  output  1  frame complete; level, four-phase handshake.
- busy  output  1  high from acceptance until return to IDLE.
- tx  output  1  UART serial line; idles high.

Behaviour:
- Reset: rst high at a rising edge → IDLE next cycle, tx=1, send_done=0, busy=0, all counters 0. Applies mid-frame: the byte in flight is abandoned and tx returns high immediately; no partial completion is reported.
- States:
  - IDLE: tx=1, busy=0, send_done=0. If send=1 at an edge, latch data into the shift buffer, set byte_idx=0 and baud_cnt=0, and go to START. Acceptance is at that edge; tx=0 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx = NBYTES-1, go to DONE; otherwise increment byte_idx and go to START. There is no extra idle gap between bytes.
  - DONE: tx=1, busy=1, send_done=1. Stay while send=1. When send=0 at an edge, go to IDLE (send_done=0 next cycle).
- Byte order: byte 0 = data[7:0] is sent first; byte k = data[8k+7:8k]; byte NBYTES-1 is sent last.
- Timing:
  - Every bit is exactly CLKS_PER_BIT cycles; the baud counter restarts at each bit boundary.
  - Frame length from first start-bit cycle to last stop-bit cycle is exactly NBYTES*10*CLKS_PER_BIT cycles.
  - send_done rises on the cycle immediately after the last stop-bit cycle.
- Data handling: the latched copy of data is used for the whole frame. Changes on data after acceptance have no effect.
- send deasserted before completion: ignored; the frame completes. On reaching DONE with send already 0, send_done is high for exactly one cycle, then IDLE.
- Back-to-back frames: a new frame is accepted only in IDLE. If send is held high continuously, the module waits in DONE and never re-sends, so a producer must drop send before requesting again. With send low one cycle then high, the next acceptance occurs at the IDLE edge.
- Counter widths: baud_cnt is clog2(CLKS_PER_BIT) bits, bit_idx 3 bits, byte_idx clog2(NBYTES) bits. No wrap beyond the terminal values.
- Outputs are registered; tx has no glitches.

Test Plan:
- Reset: hold rst=1 for 3 cycles with send=1 → tx=1, send_done=0, busy=0 throughout. Release → accept on the first edge; tx=0 on the next cycle.
- All-ones frame (CLKS_PER_BIT=4): data = all 320 bits 1, send held until done → 40 repetitions of 0 (4 cycles) then 1 (36 cycles). send_done rises exactly 1600 cycles after the first tx=0. Drop send → send_done=0 and busy=0 one cycle later.
- Data=1 (CLKS_PER_BIT=4): first byte reads start 0, bit0=1, bits1–7=0, stop 1. The remaining 39 bytes decode as 0x00. A UART monitor recovers bytes 0x01,0x00×39.
- Byte order: data[7:0]=0xA5, data[319:312]=0x3C, others 0 → monitor gets 0xA5 first and 0x3C last; 0xA5 bit sequence on tx is 1,0,1,0,0,1,0,1.
- Mid-frame disturbance:
  - Change data and drop send during byte 5 → the transmitted frame is unchanged and send_done pulses for exactly one cycle.
  - Separately, assert rst during byte 10 → tx=1 next cycle, busy=0, and no send_done.
- Re-request: after DONE, hold send=1 for 100 cycles → no new start bit. Drop send for 1 cycle then raise it → a new frame starts, with tx=0 the cycle after acceptance.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: accepts one FRAME_BITS-wide frame over a four-phase
// send/send_done handshake and transmits it as FRAME_BITS/8 bytes of 8N1
// UART on tx, byte 0 (data[7:0]) first, each byte LSB first.
//
// Handshake (valid/ready style, four-phase):
//   - The producer raises send and holds data; the frame is accepted on the
//     first rising edge where send=1 while the block is IDLE. data is copied
//     at that edge and ignored afterwards.
//   - send_done rises the cycle after the last stop-bit cycle and stays high
//     while send=1; the edge that sees send=0 returns the block to IDLE.
//   - A new frame is only accepted from IDLE, so send must drop between frames.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BITS   = 320
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [FRAME_BITS-1:0] data,
  output logic                  send_done,
  output logic                  busy,
  output logic                  tx,
  output logic [2:0]            dbg_state
);

  localparam int NBYTES = FRAME_BITS / 8;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int BYW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BYW-1:0] BYTE_LAST = BYW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_n;
  logic [BW-1:0]         baud_q, baud_n;
  logic [2:0]            bit_q, bit_n;
  logic [BYW-1:0]        byte_q, byte_n;
  // Latched frame; the byte in flight is always buf_q[7:0], the buffer
  // shifts down by one byte at each stop-to-start boundary.
  logic [FRAME_BITS-1:0] buf_q, buf_n;
  logic                  tx_n, busy_n, done_n;

  assign dbg_state = state_q;

  // Next-state logic; outputs are derived from the next state so they can be
  // registered and tx never glitches.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    buf_n   = buf_q;

    case (state_q)
      S_IDLE: begin
        if (send) begin
          buf_n   = data;
          byte_n  = '0;
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_n = '0;
          if (byte_q == BYTE_LAST) begin
            state_n = S_DONE;
          end else begin
            byte_n  = byte_q + 1'b1;
            buf_n   = buf_q >> 8;
            state_n = S_START;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!send) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    tx_n   = 1'b1;
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = buf_n[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  // State, counters, frame buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      buf_q     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      send_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_q     <= bit_n;
      byte_q    <= byte_n;
      buf_q     <= buf_n;
      tx        <= tx_n;
      busy      <= busy_n;
      send_done <= done_n;
    end
  end

endmodule
